// File: rtl/cfs_md_pkg.sv
// Shared definitions for the MD (valid/ready/data/offset/size/err) protocol:
// width helpers, the transfer legality rule and the default FIFO entry layout.
package cfs_md_pkg;

    localparam int MD_DEFAULT_DATA_WIDTH = 32;

    function automatic int md_offset_width(input int dw);
        int w;
        w = $clog2(dw / 8);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int md_size_width(input int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    // Integer arithmetic is wider than SIZE_WIDTH+1 bits, so size + offset cannot overflow.
    function automatic logic md_is_legal(input int unsigned size, input int unsigned offset, input int dw);
        int unsigned bytes_per_word;
        bytes_per_word = int'(dw / 8);
        return (size != 0) && ((size + offset) <= bytes_per_word);
    endfunction

    typedef struct packed {
        logic [MD_DEFAULT_DATA_WIDTH-1:0]                        data;
        logic [md_offset_width(MD_DEFAULT_DATA_WIDTH)-1:0]       offset;
        logic [md_size_width(MD_DEFAULT_DATA_WIDTH)-1:0]         size;
    } md_entry_t;

endpackage

// File: rtl/cfs_md_buffer_if.sv
// MD protocol bundle; the master drives valid/data/offset/size, the slave answers with ready/err.
interface cfs_md_if
    import cfs_md_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    localparam int OFFSET_WIDTH = md_offset_width(DATA_WIDTH);
    localparam int SIZE_WIDTH   = md_size_width(DATA_WIDTH);

    logic                    valid;
    logic [DATA_WIDTH-1:0]   data;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [SIZE_WIDTH-1:0]   size;
    logic                    ready;
    logic                    err;

    modport master (
        output valid, data, offset, size,
        input  ready, err
    );

    modport slave (
        input  valid, data, offset, size,
        output ready, err
    );

endinterface

// File: rtl/cfs_md_buffer_storage.sv
// DEPTH-entry register array with free-running write/read pointers; occupancy
// tracking and push/pop gating live in the parent.
module cfs_md_buffer_storage
    import cfs_md_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = md_entry_t
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr_entry,
    output entry_t rd_entry
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    entry_t                 mem [DEPTH];
    logic   [PTR_WIDTH-1:0] wr_ptr;
    logic   [PTR_WIDTH-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally on overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/cfs_md_buffer.sv
// Elastic MD buffer: legality-checks each RX transfer, queues accepted ones in a
// small FIFO and replays them on TX, keeping saturating drop / TX-error counters.
module cfs_md_buffer
    import cfs_md_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter bit DROP_ILLEGAL = 1'b1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cfs_md_if.slave                md_rx,
    cfs_md_if.master               md_tx,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [CNT_WIDTH-1:0]   drop_cnt,
    output logic [CNT_WIDTH-1:0]   tx_err_cnt
);

    localparam int OFFSET_WIDTH = md_offset_width(DATA_WIDTH);
    localparam int SIZE_WIDTH   = md_size_width(DATA_WIDTH);
    localparam int FILL_WIDTH   = $clog2(DEPTH) + 1;

    localparam logic [FILL_WIDTH-1:0] FULL_LEVEL = FILL_WIDTH'(DEPTH);

    generate
        if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
            $error("cfs_md_buffer: DATA_WIDTH must be a power of 2 and >= 8");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("cfs_md_buffer: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [OFFSET_WIDTH-1:0] offset;
        logic [SIZE_WIDTH-1:0]   size;
    } entry_t;

    entry_t wr_entry;
    entry_t rd_entry;
    logic   rx_legal;
    logic   rx_hs;
    logic   push;
    logic   drop;
    logic   pop;
    logic   tx_hs_err;

    // Ready depends only on registered occupancy, never on valid or any TX input.
    assign md_rx.ready = (fill_level != FULL_LEVEL);
    assign md_tx.valid = (fill_level != '0);

    always_comb begin
        rx_legal  = md_is_legal(32'(md_rx.size), 32'(md_rx.offset), DATA_WIDTH);
        rx_hs     = md_rx.valid && md_rx.ready;
        push      = rx_hs && (rx_legal || !DROP_ILLEGAL);
        drop      = rx_hs && !rx_legal && DROP_ILLEGAL;
        pop       = md_tx.valid && md_tx.ready;
        tx_hs_err = pop && md_tx.err;
    end

    assign md_rx.err = drop;

    always_comb begin
        wr_entry        = '0;
        wr_entry.data   = md_rx.data;
        wr_entry.offset = md_rx.offset;
        wr_entry.size   = md_rx.size;
    end

    cfs_md_buffer_storage #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_storage (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry)
    );

    // The head is masked while empty so TX fields read as zero after reset and flush.
    always_comb begin
        md_tx.data   = '0;
        md_tx.offset = '0;
        md_tx.size   = '0;
        if (md_tx.valid) begin
            md_tx.data   = rd_entry.data;
            md_tx.offset = rd_entry.offset;
            md_tx.size   = rd_entry.size;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_err_cnt <= '0;
        end else if (tx_hs_err && (tx_err_cnt != '1)) begin
            tx_err_cnt <= tx_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cfs_md_buffer.sv
// Directed bench for cfs_md_buffer: three instances (drop / keep / 2-bit counters)
// share one stimulus stream and are checked against hand-computed values.
module tb_cfs_md_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic [1:0]  rx_offset = '0;
    logic [2:0]  rx_size = '0;
    logic        tx_ready = 1'b0;
    logic        tx_err = 1'b0;

    int vectors = 0;
    int misses  = 0;

    always #5 clk = ~clk;

    cfs_md_if #(.DATA_WIDTH(32)) rx_a ();
    cfs_md_if #(.DATA_WIDTH(32)) tx_a ();
    cfs_md_if #(.DATA_WIDTH(32)) rx_b ();
    cfs_md_if #(.DATA_WIDTH(32)) tx_b ();
    cfs_md_if #(.DATA_WIDTH(32)) rx_c ();
    cfs_md_if #(.DATA_WIDTH(32)) tx_c ();

    logic [2:0]  fill_a, fill_b, fill_c;
    logic [15:0] drop_a, txerr_a, drop_b, txerr_b;
    logic [1:0]  drop_c, txerr_c;

    assign rx_a.valid = rx_valid;  assign rx_a.data = rx_data;
    assign rx_a.offset = rx_offset; assign rx_a.size = rx_size;
    assign tx_a.ready = tx_ready;  assign tx_a.err = tx_err;
    assign rx_b.valid = rx_valid;  assign rx_b.data = rx_data;
    assign rx_b.offset = rx_offset; assign rx_b.size = rx_size;
    assign tx_b.ready = tx_ready;  assign tx_b.err = tx_err;
    assign rx_c.valid = rx_valid;  assign rx_c.data = rx_data;
    assign rx_c.offset = rx_offset; assign rx_c.size = rx_size;
    assign tx_c.ready = tx_ready;  assign tx_c.err = tx_err;

    cfs_md_buffer #(.DATA_WIDTH(32), .DEPTH(4), .DROP_ILLEGAL(1'b1), .CNT_WIDTH(16)) dut_drop (
        .clk(clk), .reset_n(reset_n), .md_rx(rx_a), .md_tx(tx_a),
        .fill_level(fill_a), .drop_cnt(drop_a), .tx_err_cnt(txerr_a)
    );

    cfs_md_buffer #(.DATA_WIDTH(32), .DEPTH(4), .DROP_ILLEGAL(1'b0), .CNT_WIDTH(16)) dut_keep (
        .clk(clk), .reset_n(reset_n), .md_rx(rx_b), .md_tx(tx_b),
        .fill_level(fill_b), .drop_cnt(drop_b), .tx_err_cnt(txerr_b)
    );

    cfs_md_buffer #(.DATA_WIDTH(32), .DEPTH(4), .DROP_ILLEGAL(1'b1), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .md_rx(rx_c), .md_tx(tx_c),
        .fill_level(fill_c), .drop_cnt(drop_c), .tx_err_cnt(txerr_c)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change just after a rising edge; combinational outputs settle within #1.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [1:0] o,
                                 input logic [2:0] s, input logic r, input logic e);
        rx_valid  = v;
        rx_data   = d;
        rx_offset = o;
        rx_size   = s;
        tx_ready  = r;
        tx_err    = e;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b0;
        nextCycle();
        nextCycle();
        #1;
        reset_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        $display("[TB] start");
        resetDut();

        checkOutput("rst_fill",    64'(fill_a),      64'd0);
        checkOutput("rst_rxready", 64'(rx_a.ready),  64'd1);
        checkOutput("rst_txvalid", 64'(tx_a.valid),  64'd0);
        checkOutput("rst_txdata",  64'(tx_a.data),   64'd0);
        checkOutput("rst_rxerr",   64'(rx_a.err),    64'd0);
        checkOutput("rst_drop",    64'(drop_a),      64'd0);
        checkOutput("rst_txerr",   64'(txerr_a),     64'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(32'hA0 + i), 2'd0, 3'd4, 1'b0, 1'b0);
            checkOutput("fill_push",  64'(fill_a),   64'(i));
            checkOutput("push_rxerr", 64'(rx_a.err), 64'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 32'hEE, 2'd0, 3'd4, 1'b0, 1'b0);
        checkOutput("full_fill",    64'(fill_a),     64'd4);
        checkOutput("full_rxready", 64'(rx_a.ready), 64'd0);
        checkOutput("full_txvalid", 64'(tx_a.valid), 64'd1);
        checkOutput("full_head",    64'(tx_a.data),  64'hA0);
        nextCycle();
        checkOutput("stall_fill",   64'(fill_a),      64'd4);
        checkOutput("stall_head",   64'(tx_a.data),   64'hA0);
        checkOutput("stall_offset", 64'(tx_a.offset), 64'd0);
        checkOutput("stall_size",   64'(tx_a.size),   64'd4);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 2'd0, 3'd0, 1'b1, 1'b0);
            checkOutput("drain_valid", 64'(tx_a.valid), 64'd1);
            checkOutput("drain_data",  64'(tx_a.data),  64'(32'hA0 + i));
            nextCycle();
            checkOutput("drain_fill",  64'(fill_a),     64'(3 - i));
        end
        checkOutput("drain_empty", 64'(tx_a.valid), 64'd0);

        // Illegal transfers: off=2/size=3 overruns the word, size=0 is empty.
        resetDut();
        applyStimulus(1'b1, 32'h11, 2'd2, 3'd3, 1'b0, 1'b0);
        checkOutput("ill1_err_drop", 64'(rx_a.err), 64'd1);
        checkOutput("ill1_err_keep", 64'(rx_b.err), 64'd0);
        nextCycle();
        checkOutput("ill1_txv_drop", 64'(tx_a.valid), 64'd0);
        checkOutput("ill1_txv_keep", 64'(tx_b.valid), 64'd1);
        applyStimulus(1'b1, 32'h22, 2'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("ill2_err_drop", 64'(rx_a.err), 64'd1);
        checkOutput("ill2_err_keep", 64'(rx_b.err), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("ill_dropcnt",   64'(drop_a),      64'd2);
        checkOutput("ill_txv_drop",  64'(tx_a.valid),  64'd0);
        checkOutput("ill_fill_drop", 64'(fill_a),      64'd0);
        checkOutput("keep_dropcnt",  64'(drop_b),      64'd0);
        checkOutput("keep_fill",     64'(fill_b),      64'd2);
        checkOutput("keep_data1",    64'(tx_b.data),   64'h11);
        checkOutput("keep_off1",     64'(tx_b.offset), 64'd2);
        checkOutput("keep_size1",    64'(tx_b.size),   64'd3);
        checkOutput("sat_drop2",     64'(drop_c),      64'd2);
        applyStimulus(1'b0, 32'h0, 2'd0, 3'd0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("keep_data2",    64'(tx_b.data),   64'h22);
        checkOutput("keep_off2",     64'(tx_b.offset), 64'd0);
        checkOutput("keep_size2",    64'(tx_b.size),   64'd0);
        nextCycle();
        checkOutput("keep_empty",    64'(fill_b),      64'd0);

        // Three more drops (off=1/size=4) push the 2-bit counter past its ceiling.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 32'h33, 2'd1, 3'd4, 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("sat_drop5",  64'(drop_c), 64'd3);
        checkOutput("wide_drop5", 64'(drop_a), 64'd5);
        applyStimulus(1'b1, 32'h44, 2'd0, 3'd0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sat_hold",   64'(drop_c), 64'd3);
        checkOutput("wide_drop6", 64'(drop_a), 64'd6);

        // Streaming: push and pop every cycle; tx_err high when i%3==0 (ignored at i=0, nothing to pop).
        resetDut();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'(32'h100 + i), 2'd0, 3'd4, 1'b1, (i % 3 == 0));
            checkOutput("stream_fill", 64'(fill_a), (i == 0) ? 64'd0 : 64'd1);
            if (i > 0) begin
                checkOutput("stream_data", 64'(tx_a.data), 64'(32'h100 + i - 1));
            end
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("stream_txerr",     64'(txerr_a), 64'd6);
        checkOutput("stream_txerr_sat", 64'(txerr_c), 64'd3);

        // Asynchronous reset with three entries and one drop recorded.
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(32'h200 + i), 2'd1, 3'd2, 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h2FF, 2'd3, 3'd2, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 2'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("pre_fill", 64'(fill_a), 64'd3);
        checkOutput("pre_drop", 64'(drop_a), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("arst_fill",    64'(fill_a),      64'd0);
        checkOutput("arst_rxready", 64'(rx_a.ready),  64'd1);
        checkOutput("arst_txvalid", 64'(tx_a.valid),  64'd0);
        checkOutput("arst_data",    64'(tx_a.data),   64'd0);
        checkOutput("arst_offset",  64'(tx_a.offset), 64'd0);
        checkOutput("arst_size",    64'(tx_a.size),   64'd0);
        checkOutput("arst_drop",    64'(drop_a),      64'd0);
        checkOutput("arst_rxerr",   64'(rx_a.err),    64'd0);
        checkOutput("arst_txerr",   64'(txerr_a),     64'd0);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();
        checkOutput("post_fill",    64'(fill_a),     64'd0);
        checkOutput("post_txvalid", 64'(tx_a.valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
